// File: rtl/load_l2_arbiter.sv
// rtl/load_l2_arbiter.sv - round-robin share of one L2 load port with an ordered response FIFO
// Grants are credit-limited so a returned line always has a FIFO slot waiting for it.
module load_l2_arbiter #(
  parameter int VLEN       = 2048,
  parameter int NUM_REQ    = 4,
  parameter int RESP_DEPTH = 4,
  parameter int IDW        = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*64-1:0]   req_paddr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [VLEN-1:0]         resp_data,
  output logic                    resp_err,
  output logic                    l2_enable,
  output logic [63:0]             l2_paddr,
  input  logic [VLEN-1:0]         l2_load_data,
  input  logic                    l2_load_valid,
  output logic                    busy,
  output logic                    proto_err
);

  localparam int AW = $clog2(VLEN / 8);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_err_q, s1_err_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            proto_err_q, proto_err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [VLEN-1:0] data_mem_q [RESP_DEPTH];
  logic [IDW-1:0]  id_mem_q [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] err_mem_q;

  logic [63:0]     paddr_arr [NUM_REQ];
  logic            credit_ok, found, handshake, aligned, push, pop;
  logic [IDW-1:0]  winner, idx;
  logic [63:0]     win_paddr;
  logic [VLEN-1:0] push_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_paddr
    assign paddr_arr[g] = req_paddr[g*64 +: 64];
  end

  // A slot is reserved for the in-flight stage-1 entry as well as the queued ones.
  assign credit_ok = !reset && ((count_q + CW'(s1_valid_q)) < CW'(RESP_DEPTH));

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign handshake = found && credit_ok;
  assign win_paddr = paddr_arr[winner];
  assign aligned   = (win_paddr[AW-1:0] == '0);
  assign req_ready = handshake ? (NUM_REQ'(1) << winner) : '0;
  assign l2_enable = handshake && aligned;
  assign l2_paddr  = l2_enable ? win_paddr : 64'h0;

  assign push      = s1_valid_q;
  assign pop       = resp_valid && resp_ready;
  assign push_data = (s1_err_q || !l2_load_valid) ? '0 : l2_load_data;

  always_comb begin
    ptr_d = ptr_q;
    if (handshake) ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    s1_valid_d  = handshake;
    s1_id_d     = winner;
    s1_err_d    = !aligned;
    proto_err_d = proto_err_q | (s1_valid_q & ~s1_err_q & ~l2_load_valid);
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_id_q     <= '0;
      proto_err_q <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_mem_q   <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        id_mem_q[i]   <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_id_q     <= s1_id_d;
      proto_err_q <= proto_err_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (push) begin
        data_mem_q[wr_ptr_q] <= push_data;
        id_mem_q[wr_ptr_q]   <= s1_id_q;
        err_mem_q[wr_ptr_q]  <= s1_err_q;
      end
    end
  end

  assign resp_valid = (count_q != '0);
  assign resp_id    = id_mem_q[rd_ptr_q];
  assign resp_data  = data_mem_q[rd_ptr_q];
  assign resp_err   = err_mem_q[rd_ptr_q];
  assign busy       = s1_valid_q | resp_valid;
  assign proto_err  = proto_err_q;

  // Credit accounting makes overflow unreachable; catch any regression of that.
  always @(posedge clk) begin
    if (!reset) assert (!(push && !pop && count_q == CW'(RESP_DEPTH)));
  end

endmodule
